conf_int_mul_seq_ctrl: RTL and testbench
========================================

Name: conf_int_mul_seq_ctrl

Overview:
Issue-side sequencer for the IDCT configurable (accurate/approximate) multiplier wrapper. It generates the wrapper's state code and count0 preload counter, accepts operand pairs over a valid/ready handshake, and forwards them to the wrapper. It collects the returned 32-bit products P after a fixed latency and accumulates DOT_LEN products per row. It presents one accumulated result per row and pulses block_done after ROWS rows.

Parameters:
OP_BITWIDTH, 16, operator bit width, passed through to the wrapper.
DATA_PATH_BITWIDTH, 24, operand width of A/B.
MUL_LAT, 3, cycles from an operand issue edge to the matching valid P.
DOT_LEN, 8, products accumulated per row.
ROWS, 8, rows per block.
ACC_BITWIDTH, 40, accumulator width.

Ports:
clk  in  1  clock
rstN  in  1  synchronous active-low reset
start  in  1  one-cycle block start; only honoured in IDLE
apx_en  in  1  approximate-mode request; latched on an accepted start
in_valid  in  1  operand pair valid
in_ready  out  1  operand pair accepted when in_valid && in_ready
a_in  in  DATA_PATH_BITWIDTH  operand A
b_in  in  DATA_PATH_BITWIDTH  operand B
A_out  out  DATA_PATH_BITWIDTH  to wrapper A_in_to_wrapper
B_out  out  DATA_PATH_BITWIDTH  to wrapper B_in_to_wrapper
state_out  out  3  to wrapper state_in_to_wrapper
count0  out  9  to wrapper count0
rapx_out  out  1  to wrapper rapx
P  in  32  product from wrapper, signed
acc_out  out  ACC_BITWIDTH  row result, signed
acc_valid  out  1  row result valid
acc_ready  in  1  row result consumed when acc_valid && acc_ready
busy  out  1  high whenever state is not IDLE
block_done  out  1  one-cycle pulse after the last row is consumed

Behaviour:
- Reset (rstN=0 at a clk edge): all outputs are 0, FSM goes to IDLE, tag pipe is cleared, and the issue, collect and row counters are cleared. Reset mid-operation aborts immediately, and no partial result is emitted.
- FSM encoding is driven directly on state_out: IDLE=000, PRELOAD=001, ACC=010, FLUSH=011, OUT=100.
- IDLE: count0=0. On start, latch apx_en into rapx_out and go to PRELOAD. Start pulses outside IDLE are ignored.
- PRELOAD: count0 increments 0,1,…,63, one step per cycle, for 64 cycles total. In the cycle with count0=63, the next state is ACC. count0 returns to 0 on entering ACC.
- ACC: in_ready=1 while issued<DOT_LEN.
  - On an accepted pair: A_out<=a_in, B_out<=b_in, issued++, and a 1 is pushed into the MUL_LAT-deep tag shift register.
  - A_out and B_out hold their values when nothing is accepted. A 0 is pushed into the tag pipe on idle cycles.
  - When issued reaches DOT_LEN, the next state is FLUSH.
- Collection, active in any state:
  - When the tag emerging from the pipe is 1, acc += sign-extended P and collected++.
  - Accumulation wraps modulo 2^ACC_BITWIDTH, with no saturation.
- FLUSH: in_ready=0. When collected==DOT_LEN and the tag pipe is empty, the next state is OUT.
- OUT:
  - acc_valid=1 and acc_out=acc; acc_out stays stable while acc_ready=0.
  - On handshake: acc clears, issued and collected clear, and row++.
  - If the completed row was ROWS-1: row clears, block_done=1 for exactly the next cycle, and the next state is IDLE.
  - Otherwise the next state is ACC.
- acc_valid and in_ready are never high in the same cycle.
- First operand issue of a block occurs at the earliest 65 cycles after the start edge.

Test Plan:
1. Hold rstN=0 for 2 cycles with random inputs -> every output is 0 and state_out=000. Release, then wait 5 cycles with no start -> still IDLE.
2. Pulse start with apx_en=1 -> rapx_out=1; state_out=001 for exactly 64 cycles with count0 0..63; then state_out=010 with count0=0.
3. Feed 8 back-to-back pairs while a P model returns 5, 3 cycles after each issue -> acc_valid rises with acc_out=40. Over the row, in_ready was high for exactly 8 accepts.
4. Apply in_valid gaps (pattern 1,0,0,1…) and hold acc_ready=0 for 10 cycles in OUT -> acc_out is unchanged and in_ready=0 throughout. The result is consumed on the first cycle acc_ready=1.
5. P model returns 0xFFFFFFFF for all 8 products -> acc_out = -8, i.e. 0xFFFFFFFFF8 in 40 bits.
6. Drive rstN=0 after 4 issues in ACC -> next cycle state_out=000, acc_valid=0 and busy=0. A new start completes a full row with the correct sum.
7. Run 8 complete rows -> block_done pulses once, one cycle after the 8th acc handshake, then the FSM is in IDLE.

Source files
------------

// File: rtl/conf_int_mul_seq_ctrl_if.sv
// conf_int_mul_seq_ctrl_if: operand-issue and row-result handshakes of the multiplier sequencer
// Ports (signals):
//   in_valid/in_ready/a_in/b_in    operand pair handshake into the sequencer
//   acc_out/acc_valid/acc_ready    accumulated row result handshake out of the sequencer
// Modports: master = producer/consumer side, slave = sequencer side
interface conf_int_mul_seq_ctrl_if #(
   parameter int DATA_PATH_BITWIDTH = 24,
   parameter int ACC_BITWIDTH       = 40
);
   logic                          in_valid;
   logic                          in_ready;
   logic [DATA_PATH_BITWIDTH-1:0] a_in;
   logic [DATA_PATH_BITWIDTH-1:0] b_in;
   logic [ACC_BITWIDTH-1:0]       acc_out;
   logic                          acc_valid;
   logic                          acc_ready;
   modport master (output in_valid, a_in, b_in, acc_ready, input in_ready, acc_out, acc_valid);
   modport slave  (input in_valid, a_in, b_in, acc_ready, output in_ready, acc_out, acc_valid);
endinterface

// File: rtl/conf_int_mul_seq_ctrl.sv
// conf_int_mul_seq_ctrl: issue-side sequencer for the configurable accurate/approximate multiplier wrapper
// Ports:
//   clk, rstN            clock, synchronous active-low reset
//   start, apx_en        block start (honoured in IDLE only), approximate-mode request
//   bus (slave)          operand pair handshake in, row result handshake out
//   A_out, B_out         operands forwarded to the wrapper
//   state_out, count0    wrapper state code and preload counter
//   rapx_out             latched approximate-mode flag to the wrapper
//   P                    signed 32-bit product returned MUL_LAT cycles after issue
//   busy, block_done     not-IDLE flag, one-cycle pulse after the last row is consumed
module conf_int_mul_seq_ctrl #(
   parameter int OP_BITWIDTH        = 16,
   parameter int DATA_PATH_BITWIDTH = 24,
   parameter int MUL_LAT            = 3,
   parameter int DOT_LEN            = 8,
   parameter int ROWS               = 8,
   parameter int ACC_BITWIDTH       = 40
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          start,
   input  logic                          apx_en,
   conf_int_mul_seq_ctrl_if.slave        bus,
   output logic [DATA_PATH_BITWIDTH-1:0] A_out,
   output logic [DATA_PATH_BITWIDTH-1:0] B_out,
   output logic [2:0]                    state_out,
   output logic [8:0]                    count0,
   output logic                          rapx_out,
   input  logic signed [31:0]            P,
   output logic                          busy,
   output logic                          block_done
);
   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      PRELOAD = 3'b001,
      ACC     = 3'b010,
      FLUSH   = 3'b011,
      OUT     = 3'b100
   } state_t;
   localparam int CW = $clog2(DOT_LEN + 1);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [CW-1:0] DL       = CW'(DOT_LEN);
   localparam logic [CW-1:0] DL_LAST  = CW'(DOT_LEN - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   state_t                  state;
   logic [CW-1:0]           issued, collected;
   logic [RW-1:0]           row;
   logic [MUL_LAT-1:0]      tag;
   logic [ACC_BITWIDTH-1:0] acc;
   logic                    accept, take, unused_op;
   assign accept        = bus.in_valid && bus.in_ready;
   assign take          = bus.acc_valid && bus.acc_ready;
   assign bus.in_ready  = (state == ACC) && (issued < DL);
   assign bus.acc_valid = state == OUT;
   assign bus.acc_out   = acc;
   assign busy          = state != IDLE;
   assign state_out     = state;
   // OP_BITWIDTH only configures the downstream wrapper
   assign unused_op     = ^OP_BITWIDTH;
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state      <= IDLE;
         count0     <= '0;
         rapx_out   <= 1'b0;
         A_out      <= '0;
         B_out      <= '0;
         tag        <= '0;
         issued     <= '0;
         collected  <= '0;
         row        <= '0;
         acc        <= '0;
         block_done <= 1'b0;
      end else begin
         block_done <= 1'b0;
         // tag pipe marks which cycles carry a real product back from the wrapper
         tag <= {tag[MUL_LAT-2:0], accept};
         if (tag[MUL_LAT-1]) begin
            acc       <= acc + ACC_BITWIDTH'(P);
            collected <= collected + 1'b1;
         end
         case (state)
            IDLE: if (start) begin
               rapx_out <= apx_en;
               state    <= PRELOAD;
            end
            PRELOAD: if (count0 == 9'd63) begin
               count0 <= '0;
               state  <= ACC;
            end else count0 <= count0 + 9'd1;
            ACC: if (accept) begin
               A_out  <= bus.a_in;
               B_out  <= bus.b_in;
               issued <= issued + 1'b1;
               if (issued == DL_LAST) state <= FLUSH;
            end
            FLUSH: if (collected == DL && tag == '0) state <= OUT;
            OUT: if (take) begin
               acc       <= '0;
               issued    <= '0;
               collected <= '0;
               if (row == ROW_LAST) begin
                  row        <= '0;
                  block_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  row   <= row + 1'b1;
                  state <= ACC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conf_int_mul_seq_ctrl.sv
// tb_conf_int_mul_seq_ctrl: randomized directed bench for conf_int_mul_seq_ctrl with a product-queue wrapper model
module tb_conf_int_mul_seq_ctrl;
   localparam int DW = 24, AW = 40, LAT = 3, DL = 8, NR = 8;
   logic clk = 1'b0, rstN = 1'b0, start = 1'b0, apx_en = 1'b0;
   logic [DW-1:0] A_out, B_out;
   logic [2:0] state_out;
   logic [8:0] count0;
   logic rapx_out, busy, block_done;
   logic signed [31:0] P;
   logic [31:0] d [LAT];
   logic [31:0] pq [$];
   logic [DW-1:0] last_a = '0, last_b = '0;
   int vectors = 0, miscompares = 0;

   conf_int_mul_seq_ctrl_if #(.DATA_PATH_BITWIDTH(DW), .ACC_BITWIDTH(AW)) bus ();

   conf_int_mul_seq_ctrl #(
      .OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(DW), .MUL_LAT(LAT),
      .DOT_LEN(DL), .ROWS(NR), .ACC_BITWIDTH(AW)
   ) dut (
      .clk(clk), .rstN(rstN), .start(start), .apx_en(apx_en), .bus(bus),
      .A_out(A_out), .B_out(B_out), .state_out(state_out), .count0(count0),
      .rapx_out(rapx_out), .P(P), .busy(busy), .block_done(block_done)
   );

   always #5 clk = ~clk;

   // wrapper model: each accepted pair takes the next queued product, which appears on P
   // so that it is sampled on the third edge after the issue edge; other cycles carry noise
   always @(posedge clk) begin
      logic [31:0] v;
      v = $urandom;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1 && pq.size() > 0) v = pq.pop_front();
      d[0] <= v;
      for (int i = 1; i < LAT; i++) d[i] <= d[i-1];
   end
   assign P = d[LAT-1];

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic begin_block(input logic apx);
      @(negedge clk);
      start = 1'b1;
      apx_en = apx;
      @(negedge clk);
      start = 1'b0;
      apx_en = ~apx;
      chk("rapx", rapx_out, apx);
      for (int i = 0; i < 64; i++) begin
         chk("preload", {state_out, count0, busy}, {3'b001, 9'(i), 1'b1});
         start = (i == 10);
         @(negedge clk);
      end
      start = 1'b0;
      chk("enter_acc", {state_out, count0, rapx_out}, {3'b010, 9'd0, apx});
   endtask

   task automatic do_row(input int mode, input bit gaps, input int hold, input bit last, input int stop_at);
      longint sum;
      logic [AW-1:0] exp;
      logic [31:0] p;
      int n, cyc;
      sum = 0;
      n = 0;
      cyc = 0;
      for (int i = 0; i < stop_at; i++) begin
         p = (mode == 0) ? 32'd5 : (mode == 1) ? 32'hFFFF_FFFF : $urandom;
         pq.push_back(p);
         sum += longint'(signed'(p));
      end
      exp = sum[AW-1:0];
      while (n < stop_at && cyc < 100) begin
         chk("operand_hold", {A_out, B_out}, {last_a, last_b});
         bus.in_valid = gaps ? (cyc % 3 == 0) : 1'b1;
         bus.a_in = DW'($urandom);
         bus.b_in = DW'($urandom);
         if (bus.in_valid && bus.in_ready) begin
            n++;
            last_a = bus.a_in;
            last_b = bus.b_in;
         end
         cyc++;
         @(negedge clk);
      end
      chk("issue_count", n, stop_at);
      chk("operand_last", {A_out, B_out}, {last_a, last_b});
      bus.in_valid = 1'b0;
      if (stop_at < DL) return;
      cyc = 0;
      while (bus.acc_valid !== 1'b1 && cyc < 50) begin
         chk("flush_ready", {bus.in_ready, state_out}, {1'b0, 3'b011});
         @(negedge clk);
         cyc++;
      end
      chk("acc_valid", bus.acc_valid, 1'b1);
      chk("acc_out", bus.acc_out, exp);
      for (int i = 0; i < hold; i++) begin
         chk("out_hold", {bus.acc_valid, bus.in_ready, bus.acc_out, state_out}, {1'b1, 1'b0, exp, 3'b100});
         @(negedge clk);
      end
      bus.acc_ready = 1'b1;
      @(negedge clk);
      bus.acc_ready = 1'b0;
      chk("consumed", {bus.acc_valid, block_done, state_out, busy},
          last ? {1'b0, 1'b1, 3'b000, 1'b0} : {1'b0, 1'b0, 3'b010, 1'b1});
      if (last) begin
         @(negedge clk);
         chk("done_pulse", {block_done, state_out}, {1'b0, 3'b000});
      end
   endtask

   initial begin
      start = 1'($urandom);
      apx_en = 1'($urandom);
      bus.in_valid = 1'($urandom);
      bus.a_in = DW'($urandom);
      bus.b_in = DW'($urandom);
      bus.acc_ready = 1'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {A_out, B_out, state_out, count0, rapx_out, busy, block_done, bus.in_ready, bus.acc_valid}, '0);
      chk("reset_acc", bus.acc_out, '0);
      start = 1'b0;
      apx_en = 1'b0;
      bus.in_valid = 1'b0;
      bus.acc_ready = 1'b0;
      rstN = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("idle_wait", {state_out, count0, busy, bus.in_ready}, '0);
      end
      begin_block(1'b1);
      do_row(0, 1'b0, 0, 1'b0, DL);
      do_row(2, 1'b1, 10, 1'b0, DL);
      do_row(1, 1'b0, 0, 1'b0, DL);
      for (int r = 3; r < NR; r++) do_row(2, r[0], (r % 2 == 1) ? 3 : 0, r == NR - 1, DL);
      begin_block(1'b0);
      do_row(2, 1'b0, 0, 1'b0, 4);
      rstN = 1'b0;
      @(negedge clk);
      chk("abort", {state_out, bus.acc_valid, busy, bus.in_ready, rapx_out, bus.acc_out}, '0);
      rstN = 1'b1;
      pq.delete();
      last_a = '0;
      last_b = '0;
      begin_block(1'b1);
      do_row(2, 1'b1, 2, 1'b0, DL);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
